// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcodes, NOP encoding and types for the hazard controller
// Contents: RV32I opcode constants, NOP_INS, scoreboard entry struct, controller state enum.
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INS = 32'h00000013;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - register-usage decode of the instruction at the IF/ID output
// Ports: id_ins_i (instruction) -> rs1_o/rs2_o/rd_o (register fields),
//        use_rs1_o/use_rs2_o/has_rd_o (which fields the opcode actually uses).
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] id_ins_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o,
  output logic        has_rd_o
);

  assign rd_o  = id_ins_i[11:7];
  assign rs1_o = id_ins_i[19:15];
  assign rs2_o = id_ins_i[24:20];

  // funct3/funct7 do not affect register usage
  logic unused_funct;
  assign unused_funct = ^{id_ins_i[31:25], id_ins_i[14:12]};

  always_comb begin
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    has_rd_o  = 1'b0;
    case (id_ins_i[6:0])
      OP_R: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
        has_rd_o  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1_o = 1'b1;
        has_rd_o  = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        has_rd_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW stall and branch flush controller for the in-order pipeline
// Ports: clk, rst_n (sync active-low); id_ins (IF/ID instruction), br_taken (EX branch);
//        pc_en, if_id_en, if_id_flush, id_ex_bubble, stall (combinational controls);
//        stall_cnt (saturating stall-cycle counter).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int SB_DEPTH  = 3,
  parameter int WB_BYPASS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_ins,
  input  logic        br_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2, has_rd;

  hazard_decode u_decode (
    .id_ins_i  (id_ins),
    .rs1_o     (rs1),
    .rs2_o     (rs2),
    .rd_o      (rd),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2),
    .has_rd_o  (has_rd)
  );

  sb_entry_t   sb_q [SB_DEPTH];
  logic [31:0] stall_cnt_q;
  logic        hazard;
  hz_state_t   state;

  // With a write-before-read register file the WB entry is already visible to ID.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if ((WB_BYPASS == 0) || (k < SB_DEPTH - 1)) begin
        if (sb_q[k].valid) begin
          if (use_rs1 && (rs1 != 5'd0) && (rs1 == sb_q[k].rd)) hazard = 1'b1;
          if (use_rs2 && (rs2 != 5'd0) && (rs2 == sb_q[k].rd)) hazard = 1'b1;
        end
      end
    end
  end

  // The state is a pure function of this cycle's inputs so a dependent
  // instruction is held in the same cycle it reaches ID.
  always_comb begin
    if (br_taken)    state = FLUSH;
    else if (hazard) state = STALL;
    else             state = RUN;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall        = 1'b0;
    case (state)
      STALL: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        stall        = 1'b1;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Entries always shift: a stall inserts a bubble into EX, and a flush
  // leaves the older in-flight writers in place to complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SB_DEPTH; k++) sb_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state == RUN) begin
        sb_q[0].valid <= has_rd && (rd != 5'd0);
        sb_q[0].rd    <= rd;
      end else begin
        sb_q[0] <= '0;
      end
      for (int k = 1; k < SB_DEPTH; k++) sb_q[k] <= sb_q[k-1];
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with and without WB bypass
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_ins;
  logic        br_taken;

  logic [1:0]  pc_en_w, if_id_en_w, if_id_flush_w, id_ex_bubble_w, stall_w;
  logic [31:0] cnt_w [2];

  always #5 clk = ~clk;

  hazard_ctrl #(.SB_DEPTH(DEPTH), .WB_BYPASS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .id_ins(id_ins), .br_taken(br_taken),
    .pc_en(pc_en_w[0]), .if_id_en(if_id_en_w[0]), .if_id_flush(if_id_flush_w[0]),
    .id_ex_bubble(id_ex_bubble_w[0]), .stall(stall_w[0]), .stall_cnt(cnt_w[0])
  );

  hazard_ctrl #(.SB_DEPTH(DEPTH), .WB_BYPASS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .id_ins(id_ins), .br_taken(br_taken),
    .pc_en(pc_en_w[1]), .if_id_en(if_id_en_w[1]), .if_id_flush(if_id_flush_w[1]),
    .id_ex_bubble(id_ex_bubble_w[1]), .stall(stall_w[1]), .stall_cnt(cnt_w[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per register, the number of cycles it remains unreadable.
  int          busy [2][32];
  logic [31:0] m_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void uses(input logic [31:0] ins, output bit u1, output bit u2, output bit hr);
    u1 = 0; u2 = 0; hr = 0;
    case (ins[6:0])
      OP_R:                      begin u1 = 1; u2 = 1; hr = 1; end
      OP_IMM, OP_LOAD, OP_JALR:  begin u1 = 1; hr = 1; end
      OP_STORE, OP_BRANCH:       begin u1 = 1; u2 = 1; end
      OP_JAL, OP_LUI, OP_AUIPC:  hr = 1;
      default: ;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) busy[i][r] = 0;
      m_cnt[i] = '0;
    end
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic [31:0] ins, input logic br, input logic rstn);
    bit u1, u2, hr;
    bit e_stall [2];
    int rs1, rs2, rd;
    id_ins = ins; br_taken = br; rst_n = rstn;
    uses(ins, u1, u2, hr);
    rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]); rd = int'(ins[11:7]);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      bit hz;
      hz = (u1 && rs1 != 0 && busy[i][rs1] > 0) || (u2 && rs2 != 0 && busy[i][rs2] > 0);
      e_stall[i] = !br && hz;
      check($sformatf("stall%0d", i),        32'(stall_w[i]),        32'(e_stall[i]));
      check($sformatf("pc_en%0d", i),        32'(pc_en_w[i]),        32'(!e_stall[i]));
      check($sformatf("if_id_en%0d", i),     32'(if_id_en_w[i]),     32'(!e_stall[i]));
      check($sformatf("if_id_flush%0d", i),  32'(if_id_flush_w[i]),  32'(br));
      check($sformatf("id_ex_bubble%0d", i), 32'(id_ex_bubble_w[i]), 32'(br || e_stall[i]));
      check($sformatf("stall_cnt%0d", i),    cnt_w[i],               m_cnt[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        for (int r = 0; r < 32; r++) busy[i][r] = 0;
        m_cnt[i] = '0;
      end else begin
        if (e_stall[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
        for (int r = 0; r < 32; r++) if (busy[i][r] > 0) busy[i][r]--;
        if (!br && !e_stall[i] && hr && rd != 0) busy[i][rd] = (i == 0) ? DEPTH : DEPTH - 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(NOP_INS, 1'b0, 1'b0);
  endtask

  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADD_X2  = 32'h00108133;
  localparam logic [31:0] ADD_X0  = 32'h00000133;
  localparam logic [31:0] SW_X1   = 32'h00112023;

  initial begin
    logic [6:0] ops [10];
    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b0001111};

    // Initial reset: the scoreboard is unknown before the first edge, so no checks yet.
    rst_n = 1'b0; id_ins = NOP_INS; br_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // RAW on the immediately preceding instruction: 3 stalls (no bypass), 2 (bypass).
    do_reset();
    check("reset_cnt0", cnt_w[0], 32'd0);
    check("reset_stall0", 32'(stall_w[0]), 32'd0);
    step(ADDI_X1, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) step(ADD_X2, 1'b0, 1'b1);
    check("raw_cnt_nobypass", cnt_w[0], 32'd3);
    check("raw_cnt_bypass",   cnt_w[1], 32'd2);
    check("raw_advance_pc_en0", 32'(pc_en_w[0]), 32'd1);

    // x0 never hazards.
    do_reset();
    step(NOP_INS, 1'b0, 1'b1);
    step(ADD_X0, 1'b0, 1'b1);
    step(NOP_INS, 1'b0, 1'b1);
    check("x0_cnt0", cnt_w[0], 32'd0);
    check("x0_cnt1", cnt_w[1], 32'd0);

    // Branch taken while the dependent instruction is in ID: flush wins.
    do_reset();
    step(ADDI_X1, 1'b0, 1'b1);
    id_ins = ADD_X2; br_taken = 1'b1;
    #1;
    check("br_flush0",  32'(if_id_flush_w[0]), 32'd1);
    check("br_bubble0", 32'(id_ex_bubble_w[0]), 32'd1);
    check("br_stall0",  32'(stall_w[0]), 32'd0);
    check("br_pc_en0",  32'(pc_en_w[0]), 32'd1);
    step(ADD_X2, 1'b1, 1'b1);
    check("br_cnt0", cnt_w[0], 32'd0);
    step(NOP_INS, 1'b0, 1'b1);
    check("br_after_pc_en0", 32'(pc_en_w[0]), 32'd1);

    // Store with two intervening instructions: one stall cycle without bypass.
    do_reset();
    step(ADDI_X1, 1'b0, 1'b1);
    step(NOP_INS, 1'b0, 1'b1);
    step(NOP_INS, 1'b0, 1'b1);
    step(SW_X1, 1'b0, 1'b1);
    step(SW_X1, 1'b0, 1'b1);
    check("sw_cnt_nobypass", cnt_w[0], 32'd1);
    check("sw_cnt_bypass",   cnt_w[1], 32'd0);

    // Reset during the second stall cycle clears everything.
    do_reset();
    step(ADDI_X1, 1'b0, 1'b1);
    step(ADD_X2, 1'b0, 1'b1);
    step(ADD_X2, 1'b0, 1'b0);
    check("rst_mid_stall0", 32'(stall_w[0]), 32'd0);
    check("rst_mid_cnt0",   cnt_w[0], 32'd0);
    check("rst_mid_pc_en0", 32'(pc_en_w[0]), 32'd1);
    step(ADD_X2, 1'b0, 1'b1);

    // Randomized traffic on a few registers to provoke frequent dependencies.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step(ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
